// File: rtl/p_mul_pipe.sv
// Back-pressured sum-product multiplier: out = (in_1 + in_2) * (in_3 + in_4).
// One global advance enable moves every stage together; out_valid appears LATENCY edges after accept.
module p_mul_pipe #(
    parameter int WIDTH   = 47,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 4,
    parameter int OUT_W   = 2*(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] in_3,
    input  logic [WIDTH-1:0] in_4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SW   = WIDTH + 1;
    localparam int EXT  = OUT_W - SW;
    localparam int LAST = LATENCY + 1;

    logic             w_adv;
    logic [SW-1:0]    w_a1, w_a2, w_b1, w_b2;
    logic [SW-1:0]    w_sa, w_sb;
    logic [OUT_W-1:0] w_ea, w_eb, w_prod;

    logic             r_v1;
    logic             r_sg1;
    logic [SW-1:0]    r_sa, r_sb;
    logic [TAG_W-1:0] r_tag1;

    logic [LAST:2]    r_v;
    logic [OUT_W-1:0] r_p [2:LAST];
    logic [TAG_W-1:0] r_t [2:LAST];

    // Only a presented-but-refused result stalls the pipe; bubbles never block.
    assign w_adv    = !(r_v[LAST] && !out_ready);
    assign in_ready = w_adv;

    assign w_a1 = in_signed ? {in_1[WIDTH-1], in_1} : {1'b0, in_1};
    assign w_a2 = in_signed ? {in_2[WIDTH-1], in_2} : {1'b0, in_2};
    assign w_b1 = in_signed ? {in_3[WIDTH-1], in_3} : {1'b0, in_3};
    assign w_b2 = in_signed ? {in_4[WIDTH-1], in_4} : {1'b0, in_4};
    assign w_sa = w_a1 + w_a2;
    assign w_sb = w_b1 + w_b2;

    // Extending both sums to full result width makes the truncated product exact in either mode.
    assign w_ea   = r_sg1 ? {{EXT{r_sa[SW-1]}}, r_sa} : {{EXT{1'b0}}, r_sa};
    assign w_eb   = r_sg1 ? {{EXT{r_sb[SW-1]}}, r_sb} : {{EXT{1'b0}}, r_sb};
    assign w_prod = w_ea * w_eb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_sg1  <= 1'b0;
            r_sa   <= '0;
            r_sb   <= '0;
            r_tag1 <= '0;
            r_v    <= '0;
            for (int j = 2; j <= LAST; j++) begin
                r_p[j] <= '0;
                r_t[j] <= '0;
            end
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_sg1  <= in_signed;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_tag1 <= in_tag;
            r_v[2] <= r_v1;
            r_p[2] <= w_prod;
            r_t[2] <= r_tag1;
            for (int j = 3; j <= LAST; j++) begin
                r_v[j] <= r_v[j-1];
                r_p[j] <= r_p[j-1];
                r_t[j] <= r_t[j-1];
            end
        end
    end

    // Gating keeps out and out_tag at zero whenever nothing valid is presented, including reset.
    assign out_valid = r_v[LAST];
    assign out       = r_v[LAST] ? r_p[LAST] : '0;
    assign out_tag   = r_v[LAST] ? r_t[LAST] : '0;
endmodule

// File: tb/tb_p_mul_pipe.sv
// Scoreboard bench for p_mul_pipe: drivers push expected results, negedge monitors pop and compare.
// A second small instance covers the re-parametrised WIDTH=8 / LATENCY=2 / TAG_W=1 case.
`timescale 1ns/1ps
module tb_p_mul_pipe;
    localparam int W  = 47;
    localparam int L  = 3;
    localparam int TW = 4;
    localparam int OW = 2*(W+1);
    localparam int SW_W  = 8;
    localparam int S_L   = 2;
    localparam int S_OW  = 2*(SW_W+1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
    logic [TW-1:0] in_tag = '0;
    logic [W-1:0]  in_1 = '0, in_2 = '0, in_3 = '0, in_4 = '0;
    logic          in_ready, out_valid;
    logic [OW-1:0] out;
    logic [TW-1:0] out_tag;

    logic            s_in_valid = 1'b0, s_in_signed = 1'b0, s_out_ready = 1'b1;
    logic [0:0]      s_in_tag = '0;
    logic [SW_W-1:0] s_in_1 = '0, s_in_2 = '0, s_in_3 = '0, s_in_4 = '0;
    logic            s_in_ready, s_out_valid;
    logic [S_OW-1:0] s_out;
    logic [0:0]      s_out_tag;

    logic [TW+OW-1:0]  exp_q[$];
    int                cyc_q[$];
    logic [1+S_OW-1:0] s_exp_q[$];
    int                s_cyc_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit head_seen = 1'b0;
    bit rst_d = 1'b0;
    bit stall_d = 1'b0;
    logic [OW-1:0] prev_out;
    logic [TW-1:0] prev_tag;

    p_mul_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_tag(in_tag), .in_1(in_1), .in_2(in_2), .in_3(in_3), .in_4(in_4),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag)
    );

    p_mul_pipe #(.WIDTH(SW_W), .LATENCY(S_L), .TAG_W(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_signed(s_in_signed),
        .in_tag(s_in_tag), .in_1(s_in_1), .in_2(s_in_2), .in_3(s_in_3), .in_4(s_in_4),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out), .out_tag(s_out_tag)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- driver tasks ----------------
    task automatic send(input logic [TW-1:0] tag, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d,
                        input logic [OW-1:0] res, input bit chk_lat);
        int  tries;
        bit  done;
        in_valid = 1'b1; in_signed = sg; in_tag = tag;
        in_1 = a; in_2 = b; in_3 = c; in_4 = d;
        tries = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({tag, res});
                cyc_q.push_back(chk_lat ? cyc + 1 + L : -1);
                done = 1'b1;
            end else if (tries >= 50) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout tag=%0d: in_ready stayed 0 for %0d cycles, want 1", tag, tries);
                done = 1'b1;
            end
            tries++;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        s_in_valid = 1'b0;
    endtask

    task automatic send_s(input logic tag, input logic sg,
                          input logic [SW_W-1:0] a, input logic [SW_W-1:0] b,
                          input logic [SW_W-1:0] c, input logic [SW_W-1:0] d,
                          input logic [S_OW-1:0] res);
        s_in_valid = 1'b1; s_in_signed = sg; s_in_tag = tag;
        s_in_1 = a; s_in_2 = b; s_in_3 = c; s_in_4 = d;
        @(negedge clk);
        n_vec++;
        if (!s_in_ready) begin
            n_err++;
            $display("FAIL small_in_ready: got %0b, want 1", s_in_ready);
        end
        s_exp_q.push_back({tag, res});
        s_cyc_q.push_back(cyc + 1 + S_L);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || s_exp_q.size() != 0) && k < 100) begin
            @(posedge clk);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0 || s_exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, want 0/0", exp_q.size(), s_exp_q.size());
            exp_q.delete(); cyc_q.delete(); s_exp_q.delete(); s_cyc_q.delete();
            head_seen = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst || rst_d) begin
            n_vec++;
            if (out_valid !== 1'b0 || out !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_outputs: got valid=%b out=%h tag=%h ready=%b, want 0/0/0/1",
                         out_valid, out, out_tag, in_ready);
            end
        end else if (out_valid) begin
            n_vec++;
            if (in_ready !== out_ready) begin
                n_err++;
                $display("FAIL in_ready_follow: got in_ready=%b with out_ready=%b, want equal", in_ready, out_ready);
            end
            if (stall_d) begin
                n_vec++;
                if (out !== prev_out || out_tag !== prev_tag) begin
                    n_err++;
                    $display("FAIL stall_stable: got out=%h tag=%0d, want out=%h tag=%0d", out, out_tag, prev_out, prev_tag);
                end
            end
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_valid: got out=%h tag=%0d, want no result", out, out_tag);
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    if (cyc_q[0] >= 0) begin
                        n_vec++;
                        if (cyc !== cyc_q[0]) begin
                            n_err++;
                            $display("FAIL latency tag=%0d: got cycle %0d, want cycle %0d", out_tag, cyc, cyc_q[0]);
                        end
                    end
                end
                if (out_ready) begin
                    n_vec++;
                    if ({out_tag, out} !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL result: got out=%h tag=%0d, want out=%h tag=%0d",
                                 out, out_tag, exp_q[0][OW-1:0], exp_q[0][TW+OW-1:OW]);
                    end
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
        rst_d    = rst;
        stall_d  = !rst && out_valid && !out_ready;
        prev_out = out;
        prev_tag = out_tag;
    end

    always @(negedge clk) begin
        if (!rst && s_out_valid) begin
            n_vec++;
            if (s_exp_q.size() == 0) begin
                n_err++;
                $display("FAIL small_unexpected_valid: got out=%h, want no result", s_out);
            end else begin
                if ({s_out_tag, s_out} !== s_exp_q[0] || cyc !== s_cyc_q[0]) begin
                    n_err++;
                    $display("FAIL small_result: got out=%h tag=%0d cycle %0d, want out=%h tag=%0d cycle %0d",
                             s_out, s_out_tag, cyc, s_exp_q[0][S_OW-1:0], s_exp_q[0][S_OW], s_cyc_q[0]);
                end
                void'(s_exp_q.pop_front());
                void'(s_cyc_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    int stream_res [6] = '{2, 6, 12, 20, 30, 42};
    logic [W-1:0] all1;

    initial begin
        all1 = {W{1'b1}};
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic unsigned: (2+3)*(4+5)
        send(4'd1, 1'b0, 47'd2, 47'd3, 47'd4, 47'd5, 96'd45, 1'b1);
        idle();
        drain();

        // Maximum unsigned operands, then all zeros on the next cycle
        send(4'd2, 1'b0, all1, all1, all1, all1, 96'hFFFF_FFFF_FFFC_0000_0000_0004, 1'b1);
        send(4'd3, 1'b0, '0, '0, '0, '0, 96'd0, 1'b1);
        // Signed (-1 + -1)*(3 + 0) followed by the same bits read unsigned
        send(4'd7, 1'b1, all1, all1, 47'd3, 47'd0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 1'b1);
        send(4'd8, 1'b0, all1, all1, 47'd3, 47'd0, 96'h0000_0000_0002_FFFF_FFFF_FFFA, 1'b1);
        // Most negative operands in signed mode: (-2^46 + -2^46) * (1 + 1) = -2^48
        send(4'd9, 1'b1, {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 47'd1, 47'd1,
             96'hFFFF_FFFF_FFFF_0000_0000_0000, 1'b1);
        idle();
        drain();

        // Back-pressure: six back-to-back transactions, 4-cycle stall once the first result shows
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(TW'(i), 1'b0, W'(i), 47'd1, 47'd2, W'(i), OW'(stream_res[i]), 1'b0);
                idle();
            end
            begin
                int k;
                k = 0;
                while (!out_valid && k < 50) begin
                    @(posedge clk); #1;
                    k++;
                end
                if (!out_valid) begin
                    n_vec++; n_err++;
                    $display("FAIL stall_start: out_valid never rose within %0d cycles, want 1", k);
                end else begin
                    out_ready = 1'b0;
                    repeat (4) @(posedge clk);
                    #1 out_ready = 1'b1;
                    for (int i = 0; i < 6; i++) begin
                        @(negedge clk);
                        n_vec++;
                        if (!out_valid) begin
                            n_err++;
                            $display("FAIL no_gap beat %0d: got out_valid=0, want 1", i);
                        end
                    end
                end
            end
        join
        drain();

        // Reset while two transactions are in flight
        send(4'd10, 1'b0, 47'd1, 47'd1, 47'd1, 47'd1, 96'd4, 1'b1);
        send(4'd11, 1'b0, 47'd2, 47'd2, 47'd2, 47'd2, 96'd16, 1'b1);
        idle();
        rst = 1'b1;
        exp_q.delete(); cyc_q.delete();
        head_seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(4'd12, 1'b1, 47'd5, 47'd0, all1, all1, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFF6, 1'b1);
        idle();
        drain();

        // Re-parametrised instance: 8-bit operands, two-cycle latency
        send_s(1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 18'h3F804);
        send_s(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 18'd4);
        send_s(1'b1, 1'b1, 8'h80, 8'h80, 8'h7F, 8'h7F, 18'h30200);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past 200000 ns, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/p_mul_pipe.md
Name: p_mul_pipe

Overview:
- Parametrised, back-pressured successor to the fixed 47-bit sum-product multiplier.
- Computes out = (in_1 + in_2) * (in_3 + in_4) through a configurable-depth pipeline.
- Supports unsigned and two's-complement modes per transaction.
- Carries a sideband tag with each result.
- Sits between an operand producer and a downstream consumer that may stall.

Parameters:
- WIDTH, 47: operand width in bits (>= 2).
- LATENCY, 3: cycles from accepted input to out_valid with no stall (>= 2).
- TAG_W, 4: sideband tag width (>= 1).
- OUT_W, 2*(WIDTH+1): result width; derived, must not be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and mode valid this cycle.
- in_ready  out  1  block can accept operands this cycle.
- in_signed  in  1  1 = operands are two's complement; 0 = unsigned.
- in_tag  in  TAG_W  opaque tag; returned with the result.
- in_1  in  WIDTH  operand A0.
- in_2  in  WIDTH  operand A1.
- in_3  in  WIDTH  operand B0.
- in_4  in  WIDTH  operand B1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out  out  OUT_W  product.
- out_tag  out  TAG_W  tag of the transaction in out.

Behaviour:
- Accept: transaction accepted on an edge where in_valid && in_ready.
- Deliver: transaction delivered on an edge where out_valid && out_ready.
- Advance: adv = !(out_valid && !out_ready). in_ready = adv (combinational).
  - adv = 1: every stage (valid, data, tag, signed flag) shifts one step.
  - adv = 0: every stage holds.
  - No bubbles are collapsed: one global enable.
- Stage 1 (registered on accept):
  - sA = in_1 + in_2; sB = in_3 + in_4; each WIDTH+1 bits.
  - Signed mode: sign-extend operands before adding.
  - Unsigned mode: zero-extend operands before adding.
  - No overflow is possible at WIDTH+1.
- Stages 2..LATENCY:
  - Product sA*sB at OUT_W bits; signed or unsigned per the captured flag.
  - Signed results are sign-extended and exact (no truncation).
  - Multiplier may be split across stages 2..LATENCY.
  - Only total latency and results are specified.
- Latency: accepted at edge k with continuous adv -> out_valid=1 after edge k+LATENCY.
  - Each cycle of adv=0 adds exactly one cycle.
- Throughput: one transaction per cycle while out_ready=1.
- Order and tags: results emerge in acceptance order; out_tag matches its in_tag.
- Output stability: while out_valid && !out_ready, out and out_tag hold stable.
- in_valid=0 with adv=1: a bubble (valid=0) enters stage 1. out and out_tag are don't-care when out_valid=0.
- Pipeline full plus stall: in_ready=0. Inputs presented then are not accepted; the producer must hold them.
- Simultaneous deliver and accept: both occur in the same cycle (adv=1). No loss or duplication.
- Reset:
  - rst=1 clears all stage valids immediately (async).
  - out_valid=0, out=0, out_tag=0, in_ready=1 while rst=1 and on the first cycle after.
  - In-flight transactions are discarded; no partial result is ever presented.
  - Datapath registers may be reset or not, but out must read 0 during reset.
- in_signed is sampled only on accept; mixed modes back-to-back are legal.

Test Plan:
- Basic unsigned: in_1..4=2,3,4,5, unsigned, tag=1, out_ready=1 -> out_valid 3 cycles later; out=45 (0x2D), out_tag=1; exactly one out_valid pulse.
- Max unsigned: all operands 2^47-1 -> out=96'hFFFFFFFFFFFC000000000004; next cycle in_1..4=0 -> out=0.
- Signed mix: in_signed=1, in_1=in_2=all-ones (-1), in_3=3, in_4=0, tag=7 -> out=-6 (96'hFFF...FFA), out_tag=7.
  - Same operands with in_signed=0 issued the following cycle -> out = (2^48-2)*3 = 96'h0000000000002FFFFFFFFFFFA.
- Back-pressure: stream 6 transactions (tags 0..5); hold out_ready=0 for 4 cycles once out_valid rises.
  - in_ready falls in the same cycle out_ready falls while out_valid=1.
  - out and out_tag are stable throughout the stall.
  - After release, all 6 results are delivered in tag order with no gap.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle before either emerges -> out_valid stays 0 until a new transaction is accepted, and that transaction appears LATENCY cycles after its acceptance.
- Re-parametrised: WIDTH=8, LATENCY=2, TAG_W=1, in_1=in_2=in_3=in_4=255 unsigned -> OUT_W=18, out=510*510=260100 (18'h3F804) two cycles after accept.
